fifo_port_arbiter: RTL and testbench
====================================

FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: FIFO depth is 2**ADDR_WIDTH entries.
REQ-002 Parameter AFULL_LVL, default 6: almost_full asserts when count >= AFULL_LVL.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_req  in  1  producer requests one push; held until wr_grant.
REQ-006 rd_req  in  1  consumer requests one pop; held until rd_grant.
REQ-007 flush  in  1  synchronous clear of FIFO occupancy.
REQ-008 wr_grant  out  1  push performed this cycle.
REQ-009 rd_grant  out  1  pop performed this cycle.
REQ-010 ff_en  out  1  storage access enable.
REQ-011 ff_push_pop  out  1  1 = write, 0 = read; valid when ff_en=1, else 0.
REQ-012 wptr  out  ADDR_WIDTH+1  write pointer; MSB is the wrap bit.
REQ-013 rptr  out  ADDR_WIDTH+1  read pointer; MSB is the wrap bit.
REQ-014 full, empty  out  1 each  occupancy flags from registered pointers.
REQ-015 count  out  ADDR_WIDTH+1  occupancy, equal to wptr-rptr modulo 2**(ADDR_WIDTH+1).
REQ-016 almost_full  out  1  count >= AFULL_LVL.

Function
REQ-017 Three-state FSM: IDLE (no access), WR (push), RD (pop); state is registered, and all grant and command outputs decode from state only.
REQ-018 WR: wr_grant=1, ff_en=1, ff_push_pop=1; wptr increments by 1 at the end of the cycle.
REQ-019 RD: rd_grant=1, ff_en=1, ff_push_pop=0; rptr increments by 1 at the end of the cycle.
REQ-020 IDLE: all grants, ff_en and ff_push_pop are 0.
REQ-021 Next state is computed from the current requests and from next-cycle pointers (post-increment), so full/empty reflect the access in flight.
REQ-022 Eligibility: write eligible = wr_req & ~full_nxt; read eligible = rd_req & ~empty_nxt.
REQ-023 When only one side is eligible, the FSM enters that side's state.
REQ-024 When neither side is eligible, the FSM enters IDLE.
REQ-025 When both sides are eligible, round-robin applies: the side not served last wins; a 1-bit last_served register updates on each grant.
REQ-026 Each grant lasts exactly one cycle. Back-to-back grants to the same side are allowed when the other side is not eligible.
REQ-027 Latency: a request asserted in cycle N, with the FSM in IDLE and the side eligible, is granted in cycle N+1.
REQ-028 full = (wrap bits differ) & (low bits equal).
REQ-029 empty = (wrap bits equal) & (low bits equal).
REQ-030 Pointers wrap naturally at 2**(ADDR_WIDTH+1); the wrap bit toggles every 2**ADDR_WIDTH accesses.
REQ-031 While full, a write is never granted; the request stalls without any error.
REQ-032 While empty, a read is never granted; the request stalls without any error.
REQ-033 flush=1: at the next edge, wptr=rptr=0 and FSM=IDLE; flush overrides any in-flight increment.
REQ-034 The cycle after a flush grants nothing; last_served is preserved across flush.

Reset
REQ-035 rst=1 at an edge: FSM=IDLE, wptr=0, rptr=0, last_served=RD (the first contention goes to the write side), all grants and ff_en=0.
REQ-036 Reset values after rst: empty=1, full=0, count=0, almost_full=0.
REQ-037 rst overrides flush and any grant in progress; a grant active in the reset cycle does not advance its pointer.

Structure
REQ-038 A shared package holds the FSM state enum (IDLE/WR/RD) and the ADDR_WIDTH and AFULL_LVL defaults.
REQ-039 Sub-module fifo_status_decode (pure combinational full/empty decode) is instantiated twice: once on the registered pointers and once on the next-cycle pointers.

Verification (ADDR_WIDTH=3, AFULL_LVL=6)
REQ-040 Reset, then wr_req=1 held for 10 cycles -> 8 consecutive wr_grant from cycle 1; full=1 and wptr=4'b1000 after the 8th grant; no further grants.
REQ-041 From full, rd_req=1 held -> 8 rd_grant; empty=1 with rptr=4'b1000; rd_grant stays 0 afterwards.
REQ-042 count=4 with wr_req=rd_req=1 held -> grants alternate WR,RD,WR,RD starting with WR; count oscillates 4-5.
REQ-043 Six pushes -> almost_full rises on the cycle count reaches 6 and falls when count drops to 5.
REQ-044 flush asserted during a WR grant at count=3 -> next cycle wptr=rptr=0, empty=1, no grant that cycle.
REQ-045 rst asserted mid-WR at count=7 -> next cycle all outputs at reset values and wptr=0.

Source files
------------

// File: rtl/fifo_port_arbiter_pkg.sv
// Shared definitions for the FIFO port arbiter: FSM state encoding and parameter defaults.
package fifo_port_arbiter_pkg;

    localparam int unsigned AddrWidthDflt = 3;
    localparam int unsigned AfullLvlDflt  = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_status_decode.sv
// Combinational full/empty decode from a wrap-bit write/read pointer pair.
module fifo_status_decode #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic [ADDR_WIDTH:0] wptr_i,
    input  logic [ADDR_WIDTH:0] rptr_i,
    output logic                full_o,
    output logic                empty_o
);

    logic wrap_eq;
    logic low_eq;

    assign wrap_eq = (wptr_i[ADDR_WIDTH] == rptr_i[ADDR_WIDTH]);
    assign low_eq  = (wptr_i[ADDR_WIDTH-1:0] == rptr_i[ADDR_WIDTH-1:0]);
    assign full_o  = ~wrap_eq & low_eq;
    assign empty_o = wrap_eq & low_eq;

endmodule

// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter between a FIFO producer and consumer; one storage access per cycle,
// with pointers, occupancy flags and count derived from registered state.
module fifo_port_arbiter
    import fifo_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddrWidthDflt,
    parameter int unsigned AFULL_LVL  = AfullLvlDflt
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                flush,
    output logic                wr_grant,
    output logic                rd_grant,
    output logic                ff_en,
    output logic                ff_push_pop,
    output logic [ADDR_WIDTH:0] wptr,
    output logic [ADDR_WIDTH:0] rptr,
    output logic                full,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count,
    output logic                almost_full
);

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt;
    logic                last_rd_q;
    logic                last_rd_eff;
    logic                full_nxt, empty_nxt;
    logic                wr_elig, rd_elig;

    assign wptr_nxt = wptr_q + {{ADDR_WIDTH{1'b0}}, (state_q == StWr)};
    assign rptr_nxt = rptr_q + {{ADDR_WIDTH{1'b0}}, (state_q == StRd)};

    fifo_status_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_status_cur (
        .wptr_i  (wptr_q),
        .rptr_i  (rptr_q),
        .full_o  (full),
        .empty_o (empty)
    );

    fifo_status_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_status_nxt (
        .wptr_i  (wptr_nxt),
        .rptr_i  (rptr_nxt),
        .full_o  (full_nxt),
        .empty_o (empty_nxt)
    );

    assign wr_elig = wr_req & ~full_nxt;
    assign rd_elig = rd_req & ~empty_nxt;

    // The grant in flight this cycle counts as the most recent service.
    assign last_rd_eff = (state_q == StIdle) ? last_rd_q : (state_q == StRd);

    always_comb begin
        state_d = StIdle;
        if (wr_elig && rd_elig) begin
            state_d = last_rd_eff ? StWr : StRd;
        end else if (wr_elig) begin
            state_d = StWr;
        end else if (rd_elig) begin
            state_d = StRd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            rptr_q    <= '0;
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_eff;
            if (flush) begin
                state_q <= StIdle;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else begin
                state_q <= state_d;
                wptr_q  <= wptr_nxt;
                rptr_q  <= rptr_nxt;
            end
        end
    end

    assign wr_grant    = (state_q == StWr);
    assign rd_grant    = (state_q == StRd);
    assign ff_en       = (state_q == StWr) || (state_q == StRd);
    assign ff_push_pop = (state_q == StWr);
    assign wptr        = wptr_q;
    assign rptr        = rptr_q;
    assign count       = wptr_q - rptr_q;
    assign almost_full = (32'(count) >= AFULL_LVL);

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an occupancy-level model.
module tb_fifo_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       flush = 1'b0;
    logic       wr_grant, rd_grant, ff_en, ff_push_pop;
    logic [3:0] wptr, rptr, count;
    logic       full, empty, almost_full;

    int total = 0;
    int bad   = 0;

    // Model: pushes/pops performed since last clear, grant in flight (0 none, 1 wr, 2 rd),
    // and which side was served most recently (1 wr, 2 rd).
    int m_wcnt  = 0;
    int m_rcnt  = 0;
    int m_grant = 0;
    int m_last  = 2;

    fifo_port_arbiter #(.ADDR_WIDTH(3), .AFULL_LVL(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .flush       (flush),
        .wr_grant    (wr_grant),
        .rd_grant    (rd_grant),
        .ff_en       (ff_en),
        .ff_push_pop (ff_push_pop),
        .wptr        (wptr),
        .rptr        (rptr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic w, input logic r, input logic f, input logic rs);
        int  occ;
        bit  we, re;
        if (rs) begin
            m_wcnt = 0; m_rcnt = 0; m_grant = 0; m_last = 2;
        end else begin
            if (m_grant == 1) m_wcnt++;
            if (m_grant == 2) m_rcnt++;
            if (m_grant != 0) m_last = m_grant;
            if (f) begin
                m_wcnt = 0; m_rcnt = 0; m_grant = 0;
            end else begin
                occ = m_wcnt - m_rcnt;
                we  = w && (occ < 8);
                re  = r && (occ > 0);
                if (we && re)  m_grant = (m_last == 1) ? 2 : 1;
                else if (we)   m_grant = 1;
                else if (re)   m_grant = 2;
                else           m_grant = 0;
            end
        end
    endtask

    task automatic check_all();
        int occ;
        occ = m_wcnt - m_rcnt;
        check_eq("wr_grant", 32'(wr_grant), 32'(m_grant == 1));
        check_eq("rd_grant", 32'(rd_grant), 32'(m_grant == 2));
        check_eq("ff_en", 32'(ff_en), 32'(m_grant != 0));
        check_eq("ff_push_pop", 32'(ff_push_pop), 32'(m_grant == 1));
        check_eq("wptr", 32'(wptr), 32'(m_wcnt % 16));
        check_eq("rptr", 32'(rptr), 32'(m_rcnt % 16));
        check_eq("count", 32'(count), 32'(occ));
        check_eq("full", 32'(full), 32'(occ == 8));
        check_eq("empty", 32'(empty), 32'(occ == 0));
        check_eq("almost_full", 32'(almost_full), 32'(occ >= 6));
    endtask

    task automatic step(input logic w, input logic r, input logic f, input logic rs);
        @(negedge clk);
        wr_req = w; rd_req = r; flush = f; rst = rs;
        @(posedge clk);
        model_edge(w, r, f, rs);
        #1;
        check_all();
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Fill from empty, then drain.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check_eq("full_after_fill", 32'(full), 32'd1);
        check_eq("wptr_after_fill", 32'(wptr), 32'd8);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        check_eq("empty_after_drain", 32'(empty), 32'd1);
        check_eq("rptr_after_drain", 32'(rptr), 32'd8);

        // Reach count 4 with the read side served last, then contend.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("count_before_contend", 32'(count), 32'd4);
        step(1, 1, 0, 0);
        check_eq("contend_first_wr", 32'(wr_grant), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // almost_full threshold crossing both ways.
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Flush during a write grant at count 3.
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check_eq("flush_no_grant", 32'(ff_en), 32'd0);
        check_eq("flush_wptr", 32'(wptr), 32'd0);

        // Reset during a write grant at count 7.
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check_eq("count_before_rst", 32'(count), 32'd7);
        step(1, 0, 0, 1);
        check_eq("rst_wptr", 32'(wptr), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
